// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master and slave-side blocks.
// Pure declarations: no logic, no latency.
// No handshake of its own.
package spi_pkg;

    // Transfer phase of the serial engine.
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SETUP    = 2'd1,
        TRANSFER = 2'd2,
        HOLD     = 2'd3
    } spi_state_e;

    // SPI mode as {cpol, cpha}.
    localparam logic [1:0] MODE0 = 2'b00;
    localparam logic [1:0] MODE1 = 2'b01;
    localparam logic [1:0] MODE2 = 2'b10;
    localparam logic [1:0] MODE3 = 2'b11;

    // Per-transfer mode captured on accept.
    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // True when mosi should move on this SCLK edge; the other edge samples miso.
    function automatic logic drive_on_edge(input logic cpha, input logic leading);
        return cpha ? leading : ~leading;
    endfunction

endpackage

// File: rtl/spi_master_gen_if.sv
// Start/response bus between the control logic and the SPI master.
// Pure wiring: no latency.
// start_valid/start_ready handshake; data_out/done are fire-and-forget.
interface spi_master_gen_if #(
    parameter int DATA_WIDTH = 16,
    parameter int SEL_W      = 2
);
    logic                  start_valid;
    logic                  start_ready;
    logic [DATA_WIDTH-1:0] data_in;
    logic [SEL_W-1:0]      ss_sel;
    logic                  cpol;
    logic                  cpha;
    logic                  busy;
    logic                  done;
    logic [DATA_WIDTH-1:0] data_out;

    // Control-logic side: issues requests, consumes results.
    modport master (
        output start_valid, data_in, ss_sel, cpol, cpha,
        input  start_ready, busy, done, data_out
    );

    // SPI engine side.
    modport slave (
        input  start_valid, data_in, ss_sel, cpol, cpha,
        output start_ready, busy, done, data_out
    );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one-cycle tick every CLK_DIV enabled cycles.
// First tick CLK_DIV cycles after clr; count holds while en is low.
// No backpressure; clr has priority over en.
module spi_clk_div #(
    parameter int CLK_DIV = 400
) (
    input  logic CLOCK_50,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);
    localparam int            CW   = $clog2(CLK_DIV) + 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q;

    // Count enabled cycles, wrapping after each tick; never free-runs when disabled.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
        end
    end

    assign tick = en && !clr && (cnt_q == LAST);

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised full-duplex SPI master, per-transfer CPOL/CPHA and slave select.
// done pulses (2*DATA_WIDTH+2)*CLK_DIV+1 cycles after accept.
// start_ready low from accept through the done cycle; requests are not queued.
module spi_master_gen #(
    parameter int DATA_WIDTH = 16,
    parameter int CLK_DIV    = 400,
    parameter int NUM_SLAVES = 4,
    parameter int SEL_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
    input  logic                  CLOCK_50,
    input  logic                  rst_n,
    spi_master_gen_if.slave       bus,
    input  logic                  miso,
    output logic                  mosi,
    output logic                  sclk,
    output logic [NUM_SLAVES-1:0] ss_n
);
    import spi_pkg::*;

    localparam int             ECW       = $clog2(2 * DATA_WIDTH) + 1;
    localparam logic [ECW-1:0] LAST_EDGE = ECW'(2 * DATA_WIDTH - 1);

    spi_state_e            state_q, state_d;
    spi_mode_t             mode_q;
    logic [DATA_WIDTH-1:0] tx_q;
    logic [DATA_WIDTH-1:0] rx_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic [ECW-1:0]        edge_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  tick;
    logic                  accept;
    logic                  start_ready;
    logic                  leading;
    logic                  drive_en;
    logic                  sample_en;
    logic                  finish;
    logic [NUM_SLAVES-1:0] ss_dec;

    // Ready is withheld in the done cycle so a new accept lands one cycle later.
    assign start_ready = (state_q == IDLE) && !done_q;
    assign accept      = bus.start_valid && start_ready;

    assign bus.start_ready = start_ready;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.data_out    = data_out_q;

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .CLOCK_50 (CLOCK_50),
        .rst_n    (rst_n),
        .clr      (accept),
        .en       (state_q != IDLE),
        .tick     (tick)
    );

    // One-hot active-low select; out-of-range ss_sel leaves every line high.
    always_comb begin
        ss_dec = '1;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (bus.ss_sel == SEL_W'(i)) begin
                ss_dec[i] = 1'b0;
            end
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and per-tick strobes: which SCLK edges drive and which sample.
    always_comb begin
        state_d   = state_q;
        leading   = 1'b0;
        drive_en  = 1'b0;
        sample_en = 1'b0;
        finish    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick) begin
                    state_d = TRANSFER;
                end
            end
            TRANSFER: begin
                if (tick) begin
                    // Even edge count means the next toggle leaves the idle level.
                    leading = ~edge_q[0];
                    if (drive_on_edge(mode_q.cpha, leading)) begin
                        // cpha=0 has nothing left to shift after the final edge.
                        drive_en = (edge_q != LAST_EDGE);
                    end else begin
                        sample_en = 1'b1;
                    end
                    if (edge_q == LAST_EDGE) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Serial pins, selects and status flags.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            ss_n   <= '1;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mode_q <= '0;
            edge_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                mode_q <= '{cpol: bus.cpol, cpha: bus.cpha};
                sclk   <= bus.cpol;
                ss_n   <= ss_dec;
                busy_q <= 1'b1;
                edge_q <= '0;
                // cpha=0 must present the MSB before the first (sampling) edge.
                if (!bus.cpha) begin
                    mosi <= bus.data_in[DATA_WIDTH-1];
                end
            end
            if (state_q == TRANSFER && tick) begin
                sclk   <= ~sclk;
                edge_q <= edge_q + ECW'(1);
            end
            if (drive_en) begin
                mosi <= tx_q[DATA_WIDTH-1];
            end
            if (finish) begin
                sclk   <= mode_q.cpol;
                ss_n   <= '1;
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    // Transmit and receive shift registers plus the held result word.
    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            tx_q       <= '0;
            rx_q       <= '0;
            data_out_q <= '0;
        end else begin
            if (accept) begin
                // With cpha=0 the MSB is already on mosi, so queue the rest.
                tx_q <= bus.cpha ? bus.data_in : {bus.data_in[DATA_WIDTH-2:0], 1'b0};
                rx_q <= '0;
            end
            if (drive_en) begin
                tx_q <= {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
            if (sample_en) begin
                rx_q <= {rx_q[DATA_WIDTH-2:0], miso};
            end
            if (finish) begin
                data_out_q <= rx_q;
            end
        end
    end

endmodule
